// File: rtl/alu_shro_unit.sv
// Multi-cycle ALU / shift-rotate unit: one-cycle ALU ops, bit-serial shifts and rotates.
// Operands are captured on start, so inputs may change while an operation is in flight.
module alu_shro_unit #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               unitSel,
  input  logic [2:0]         ALUOperation,
  input  logic [1:0]         SHROOperation,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               CEn,
  input  logic               ZEn,
  output logic [WIDTH-1:0]   result,
  output logic               C,
  output logic               Z,
  output logic               busy,
  output logic               done
);

  localparam int unsigned EW = WIDTH + 1;

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} stateT;

  stateT              state, stateNext;
  logic [WIDTH-1:0]   opA, opANext;
  logic [WIDTH-1:0]   opB, opBNext;
  logic [2:0]         aluOp, aluOpNext;
  logic [1:0]         shroOp, shroOpNext;
  logic [SHAMT_W-1:0] counter, counterNext;
  logic               shamtNz, shamtNzNext;
  logic               cEnQ, cEnNext;
  logic               zEnQ, zEnNext;
  logic               lastOut, lastOutNext;
  logic [WIDTH-1:0]   resultNext;
  logic               cNext, zNext, busyNext, doneNext;

  logic [EW-1:0]      wide;
  logic [WIDTH-1:0]   aluRes;
  logic               aluCarry, aluWritesC;
  logic [WIDTH-1:0]   shiftVal;
  logic               shiftOut;

  // Combinational ALU on the captured operands; C here is still the start-edge value.
  always_comb begin
    wide       = '0;
    aluRes     = '0;
    aluCarry   = 1'b0;
    aluWritesC = 1'b0;
    case (aluOp)
      3'b000: begin
        wide       = {1'b0, opA} + {1'b0, opB};
        aluRes     = wide[WIDTH-1:0];
        aluCarry   = wide[WIDTH];
        aluWritesC = 1'b1;
      end
      3'b001: begin
        wide       = {1'b0, opA} + {1'b0, opB} + EW'(C);
        aluRes     = wide[WIDTH-1:0];
        aluCarry   = wide[WIDTH];
        aluWritesC = 1'b1;
      end
      3'b010: begin
        wide       = {1'b0, opA} - {1'b0, opB};
        aluRes     = wide[WIDTH-1:0];
        aluCarry   = wide[WIDTH];
        aluWritesC = 1'b1;
      end
      3'b011: begin
        wide       = {1'b0, opA} - {1'b0, opB} - EW'(C);
        aluRes     = wide[WIDTH-1:0];
        aluCarry   = wide[WIDTH];
        aluWritesC = 1'b1;
      end
      3'b100:  aluRes = opA & opB;
      3'b101:  aluRes = opA | opB;
      3'b110:  aluRes = opA ^ opB;
      default: aluRes = opB;
    endcase
  end

  // One-bit step of the shift register and the bit leaving it.
  always_comb begin
    shiftVal = opA;
    shiftOut = 1'b0;
    case (shroOp)
      2'b00: begin
        shiftVal = {opA[WIDTH-2:0], 1'b0};
        shiftOut = opA[WIDTH-1];
      end
      2'b01: begin
        shiftVal = {1'b0, opA[WIDTH-1:1]};
        shiftOut = opA[0];
      end
      2'b10: begin
        shiftVal = {opA[WIDTH-2:0], opA[WIDTH-1]};
        shiftOut = opA[WIDTH-1];
      end
      default: begin
        shiftVal = {opA[0], opA[WIDTH-1:1]};
        shiftOut = opA[0];
      end
    endcase
  end

  // Next-state and next-register logic.
  always_comb begin
    stateNext   = state;
    opANext     = opA;
    opBNext     = opB;
    aluOpNext   = aluOp;
    shroOpNext  = shroOp;
    counterNext = counter;
    shamtNzNext = shamtNz;
    cEnNext     = cEnQ;
    zEnNext     = zEnQ;
    lastOutNext = lastOut;
    resultNext  = result;
    cNext       = C;
    zNext       = Z;
    busyNext    = 1'b0;
    doneNext    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          opANext     = a;
          opBNext     = b;
          aluOpNext   = ALUOperation;
          shroOpNext  = SHROOperation;
          counterNext = shamt;
          shamtNzNext = (shamt != '0);
          cEnNext     = CEn;
          zEnNext     = ZEn;
          lastOutNext = 1'b0;
          busyNext    = 1'b1;
          stateNext   = unitSel ? SHIFT : EXEC;
        end
      end
      EXEC: begin
        resultNext = aluRes;
        if (cEnQ && aluWritesC) cNext = aluCarry;
        if (zEnQ) zNext = (aluRes == '0);
        doneNext  = 1'b1;
        stateNext = DONE;
      end
      SHIFT: begin
        if (counter != '0) begin
          opANext     = shiftVal;
          lastOutNext = shiftOut;
          counterNext = counter - SHAMT_W'(1);
          busyNext    = 1'b1;
        end else begin
          resultNext = opA;
          // A zero-distance shift moves no bit out, so C keeps its value.
          if (cEnQ && shamtNz) cNext = lastOut;
          if (zEnQ) zNext = (opA == '0);
          doneNext  = 1'b1;
          stateNext = DONE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      opA     <= '0;
      opB     <= '0;
      aluOp   <= '0;
      shroOp  <= '0;
      counter <= '0;
      shamtNz <= 1'b0;
      cEnQ    <= 1'b0;
      zEnQ    <= 1'b0;
      lastOut <= 1'b0;
      result  <= '0;
      C       <= 1'b0;
      Z       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      opA     <= opANext;
      opB     <= opBNext;
      aluOp   <= aluOpNext;
      shroOp  <= shroOpNext;
      counter <= counterNext;
      shamtNz <= shamtNzNext;
      cEnQ    <= cEnNext;
      zEnQ    <= zEnNext;
      lastOut <= lastOutNext;
      result  <= resultNext;
      C       <= cNext;
      Z       <= zNext;
      busy    <= busyNext;
      done    <= doneNext;
    end
  end

endmodule

// File: tb/tb_alu_shro_unit.sv
// Directed bench for alu_shro_unit (WIDTH=8): hand-computed vectors checked with immediate assertions.
module tb_alu_shro_unit;

  logic       clk;
  logic       rst;
  logic       start;
  logic       unitSel;
  logic [2:0] ALUOperation;
  logic [1:0] SHROOperation;
  logic [7:0] a, b;
  logic [2:0] shamt;
  logic       CEn, ZEn;
  logic [7:0] result;
  logic       C, Z, busy, done;

  int cmpCount;
  int errCount;
  int lat;
  int busyCyc;
  int doneSeen;

  alu_shro_unit #(.WIDTH(8), .SHAMT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .unitSel(unitSel),
    .ALUOperation(ALUOperation), .SHROOperation(SHROOperation),
    .a(a), .b(b), .shamt(shamt), .CEn(CEn), .ZEn(ZEn),
    .result(result), .C(C), .Z(Z), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmpCount++;
    assert (obs === exp) else begin
      errCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one request and consume its start edge.
  task automatic launch(input logic sel, input logic [2:0] aop, input logic [1:0] sop,
                        input logic [7:0] va, input logic [7:0] vb, input logic [2:0] sa,
                        input logic ce, input logic ze);
    unitSel = sel; ALUOperation = aop; SHROOperation = sop;
    a = va; b = vb; shamt = sa; CEn = ce; ZEn = ze;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Edges from the start edge until done is sampled high, plus busy cycles seen.
  task automatic waitDone(output int latency, output int bcyc);
    int n;
    n = 0;
    bcyc = busy ? 1 : 0;
    do begin
      step();
      n++;
      if (busy) bcyc++;
    end while (!done && n < 40);
    latency = n + 1;
  endtask

  initial begin
    cmpCount = 0; errCount = 0;
    rst = 1'b1; start = 1'b0; unitSel = 1'b0; ALUOperation = 3'd0; SHROOperation = 2'd0;
    a = 8'h00; b = 8'h00; shamt = 3'd0; CEn = 1'b0; ZEn = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_result", 32'(result), 32'h00);
    chk("rst_C", 32'(C), 32'd0);
    chk("rst_Z", 32'(Z), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // ADD F0+20
    launch(1'b0, 3'b000, 2'b00, 8'hF0, 8'h20, 3'd0, 1'b1, 1'b1);
    chk("add_busy", 32'(busy), 32'd1);
    waitDone(lat, busyCyc);
    chk("add_lat", 32'(lat), 32'd2);
    chk("add_res", 32'(result), 32'h10);
    chk("add_C", 32'(C), 32'd1);
    chk("add_Z", 32'(Z), 32'd0);
    step();
    chk("add_done_pulse", 32'(done), 32'd0);
    chk("add_busy_end", 32'(busy), 32'd0);

    // ADDC 01+01+1
    launch(1'b0, 3'b001, 2'b00, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1);
    waitDone(lat, busyCyc);
    chk("addc_res", 32'(result), 32'h03);
    chk("addc_C", 32'(C), 32'd0);
    step();

    // SUB 05-05
    launch(1'b0, 3'b010, 2'b00, 8'h05, 8'h05, 3'd0, 1'b1, 1'b1);
    waitDone(lat, busyCyc);
    chk("sub0_res", 32'(result), 32'h00);
    chk("sub0_Z", 32'(Z), 32'd1);
    chk("sub0_C", 32'(C), 32'd0);
    step();

    // SUB 03-04 borrows
    launch(1'b0, 3'b010, 2'b00, 8'h03, 8'h04, 3'd0, 1'b1, 1'b1);
    waitDone(lat, busyCyc);
    chk("subb_res", 32'(result), 32'hFF);
    chk("subb_C", 32'(C), 32'd1);
    chk("subb_Z", 32'(Z), 32'd0);
    step();

    // ROR 81 by 3
    launch(1'b1, 3'b000, 2'b11, 8'h81, 8'h00, 3'd3, 1'b1, 1'b1);
    waitDone(lat, busyCyc);
    chk("ror_lat", 32'(lat), 32'd5);
    chk("ror_busy_cycles", 32'(busyCyc), 32'd4);
    chk("ror_res", 32'(result), 32'h30);
    chk("ror_C", 32'(C), 32'd0);
    step();
    chk("ror_done_pulse", 32'(done), 32'd0);

    // SHL C1 by 2
    launch(1'b1, 3'b000, 2'b00, 8'hC1, 8'h00, 3'd2, 1'b1, 1'b1);
    waitDone(lat, busyCyc);
    chk("shl_lat", 32'(lat), 32'd4);
    chk("shl_res", 32'(result), 32'h04);
    chk("shl_C", 32'(C), 32'd1);
    step();

    // ROL 0F by 4 while start is re-asserted with other operands mid-flight
    launch(1'b1, 3'b000, 2'b10, 8'h0F, 8'h00, 3'd4, 1'b1, 1'b1);
    unitSel = 1'b0; ALUOperation = 3'b111; a = 8'h33; b = 8'h77; shamt = 3'd1;
    CEn = 1'b0; ZEn = 1'b0; start = 1'b1;
    step();
    step();
    start = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 6 && !done; i++) step();
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_res", 32'(result), 32'hF0);
    chk("ign_C", 32'(C), 32'd0);
    chk("ign_Z", 32'(Z), 32'd0);
    step();
    step();
    chk("ign_no_restart", 32'(busy), 32'd0);
    chk("ign_res_hold", 32'(result), 32'hF0);

    // Set C, then ADD with CEn=0 keeps it
    launch(1'b0, 3'b010, 2'b00, 8'h03, 8'h04, 3'd0, 1'b1, 1'b1);
    waitDone(lat, busyCyc);
    step();
    launch(1'b0, 3'b000, 2'b00, 8'h01, 8'h01, 3'd0, 1'b0, 1'b1);
    waitDone(lat, busyCyc);
    chk("cen0_res", 32'(result), 32'h02);
    chk("cen0_C", 32'(C), 32'd1);
    step();

    // XOR 5A^5A with ZEn=0 keeps Z=0
    launch(1'b0, 3'b110, 2'b00, 8'h5A, 8'h5A, 3'd0, 1'b1, 1'b0);
    waitDone(lat, busyCyc);
    chk("xor_res", 32'(result), 32'h00);
    chk("xor_Z", 32'(Z), 32'd0);
    chk("xor_C", 32'(C), 32'd1);
    step();

    // SHR by 0: result=a, C untouched
    launch(1'b1, 3'b000, 2'b01, 8'h55, 8'h00, 3'd0, 1'b1, 1'b1);
    waitDone(lat, busyCyc);
    chk("sh0_lat", 32'(lat), 32'd2);
    chk("sh0_res", 32'(result), 32'h55);
    chk("sh0_C", 32'(C), 32'd1);
    chk("sh0_Z", 32'(Z), 32'd0);
    step();

    // PASSB leaves C alone
    launch(1'b0, 3'b111, 2'b00, 8'h12, 8'h80, 3'd0, 1'b1, 1'b1);
    waitDone(lat, busyCyc);
    chk("passb_res", 32'(result), 32'h80);
    chk("passb_C", 32'(C), 32'd1);
    step();

    // SUBC 10-0F-1
    launch(1'b0, 3'b011, 2'b00, 8'h10, 8'h0F, 3'd0, 1'b1, 1'b1);
    waitDone(lat, busyCyc);
    chk("subc_res", 32'(result), 32'h00);
    chk("subc_C", 32'(C), 32'd0);
    chk("subc_Z", 32'(Z), 32'd1);
    step();

    // OR with ZEn=0 keeps Z=1
    launch(1'b0, 3'b101, 2'b00, 8'h01, 8'h80, 3'd0, 1'b1, 1'b0);
    waitDone(lat, busyCyc);
    chk("or_res", 32'(result), 32'h81);
    chk("or_Z", 32'(Z), 32'd1);
    step();

    // SHL FF by 7 aborted by reset in the third SHIFT cycle
    launch(1'b1, 3'b000, 2'b00, 8'hFF, 8'h00, 3'd7, 1'b1, 1'b1);
    step();
    step();
    chk("abort_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_res", 32'(result), 32'h00);
    chk("abort_C", 32'(C), 32'd0);
    chk("abort_Z", 32'(Z), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    doneSeen = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) doneSeen++;
      step();
    end
    chk("abort_no_done", 32'(doneSeen), 32'd0);
    chk("abort_busy_after", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule

// File: doc/alu_shro_unit.md
ALU_SHRO_UNIT -- requirements
Module: alu_shro_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width; power of two, at least 4.
REQ-002 SHALL have parameter SHAMT_W, default 3, shift-amount width, equal to log2(WIDTH).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port unitSel  input  1  0 = ALU operation, 1 = shift/rotate operation.
REQ-007 SHALL have port ALUOperation  input  3  ALU opcode (REQ-015).
REQ-008 SHALL have port SHROOperation  input  2  shift/rotate opcode (REQ-017).
REQ-009 SHALL have ports a, b  input  WIDTH  operands; b unused for shift/rotate.
REQ-010 SHALL have port shamt  input  SHAMT_W  shift/rotate distance, 0..WIDTH-1.
REQ-011 SHALL have ports CEn, ZEn  input  1 each  enable update of C and Z flags at completion.
REQ-012 SHALL have port result  output  WIDTH  registered result; holds until the next completion.
REQ-013 SHALL have ports C, Z  output  1 each  registered carry/borrow flag and zero flag.
REQ-014 SHALL have ports busy, done  output  1 each  busy high in EXEC/SHIFT; done is a one-cycle pulse in DONE.

Function
REQ-015 ALU opcodes SHALL be:
- 000 ADD a+b
- 001 ADDC a+b+C
- 010 SUB a-b
- 011 SUBC a-b-C
- 100 AND
- 101 OR
- 110 XOR
- 111 PASSB (result = b)
REQ-016 Carry rules SHALL be:
- ADD/ADDC: C = carry out of bit WIDTH-1.
- SUB/SUBC: C = borrow, 1 when the unsigned true difference is negative.
- Logic ops and PASSB: C is left unchanged.
- All arithmetic is modulo 2^WIDTH.
REQ-017 SHRO opcodes SHALL be:
- 00 SHL: logical left, 0 shifted in.
- 01 SHR: logical right, 0 shifted in.
- 10 ROL.
- 11 ROR.
- For all four, C = the last bit shifted or rotated out.
REQ-018 FSM SHALL have states IDLE, EXEC, SHIFT, DONE.
REQ-019 In IDLE with start=1, the unit SHALL capture a, b, shamt, opcodes, unitSel, CEn and ZEn, then go to EXEC if unitSel=0 or SHIFT if unitSel=1.
REQ-020 EXEC SHALL take one cycle: result and enabled flags written at its closing edge, then state DONE; done asserts 2 edges after the start edge.
REQ-021 SHIFT SHALL load the captured a into a shift register and a counter with shamt. Each SHIFT cycle with counter>0 moves one bit and decrements the counter. With counter=0, result and enabled flags are written and state goes to DONE. done asserts shamt+2 edges after the start edge.
REQ-022 shamt=0 SHALL give result=a with C unchanged; Z still updates if ZEn=1.
REQ-023 At completion, Z = (result==0) SHALL be written when the captured ZEn=1. C SHALL be written per REQ-016/017 when the captured CEn=1. A disabled flag holds its value.
REQ-024 DONE SHALL last exactly one cycle and then return to IDLE unconditionally; start is ignored in EXEC, SHIFT and DONE.
REQ-025 Input changes after capture SHALL NOT affect the operation in flight.
REQ-026 ADDC/SUBC SHALL use the C value held at the start edge.

Reset
REQ-027 With rst=1 at a rising edge, the unit SHALL enter IDLE and set result=0, C=0, Z=0, busy=0, done=0, counter=0; rst has priority over start.
REQ-028 Reset during EXEC/SHIFT/DONE SHALL abort the operation with no done pulse and no flag update beyond the reset values.

Verification (WIDTH=8)
REQ-029 ADD a=0xF0 b=0x20, CEn=ZEn=1 -> result=0x10, C=1, Z=0; done exactly 2 edges after start.
REQ-030 Then ADDC a=0x01 b=0x01 -> result=0x03, C=0. Then SUB a=0x05 b=0x05 -> result=0x00, Z=1, C=0. Then SUB a=0x03 b=0x04 -> result=0xFF, C=1.
REQ-031 ROR a=0x81 shamt=3 -> result=0x30, C=0, busy high 4 cycles, done at edge 5 after start. SHL a=0xC1 shamt=2 -> result=0x04, C=1.
REQ-032 SHL a=0xFF shamt=7, then rst asserted in the 3rd SHIFT cycle -> result=0x00, C=0, Z=0, busy=0, no done pulse.
REQ-033 start re-asserted with different operands while busy -> ignored, first result unaffected. Operation with CEn=0 after C=1 -> C stays 1. XOR a=b=0x5A with ZEn=0 -> result=0x00, Z unchanged.
